sevenseg_scan_n: RTL and testbench

Time-multiplexed driver for an NDIG-digit common-anode seven-segment display with active-low anodes and segments. Each digit is held in an internal register using the 7-bit extended per-digit format: enable, decimal point, and a 5-bit glyph code. The block scans the digits at a fixed slot rate and applies per-slot brightness PWM. It sits between the datapath, which writes digit registers, and the board display pins.

---
 rtl/sevenseg_scan_n_if.sv | 21 ++
 rtl/sevenseg_scan_n.sv | 107 ++++++++++
 tb/tb_sevenseg_scan_n.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_scan_n_if.sv
// Datapath write port, brightness control and display pins of the seven-segment scanner.
interface sevenseg_scan_n_if #(
  parameter int NDIG = 8,
  parameter int BW   = 17
);
  localparam int AW = $clog2(NDIG);

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [6:0]      wr_data;
  logic [BW-1:0]   bright;
  logic [NDIG-1:0] an_n;
  logic [6:0]      segs_n;
  logic            dp_n;
  logic            frame;

  modport master (output wr_en, wr_addr, wr_data, bright,
                  input  an_n, segs_n, dp_n, frame);
  modport slave  (input  wr_en, wr_addr, wr_data, bright,
                  output an_n, segs_n, dp_n, frame);
endinterface

// File: rtl/sevenseg_scan_n.sv
// Time-multiplexed common-anode seven-segment driver with per-slot PWM brightness.
// Digit words are latched into a shadow at slot start so writes never disturb a live slot.
module sevenseg_scan_n #(
  parameter int NDIG = 8,
  parameter int DIV  = 100000,
  parameter int BW   = $clog2(DIV+1)
) (
  input  logic            clk,
  input  logic            rst,
  sevenseg_scan_n_if.slave bus
);
  localparam int AW = $clog2(NDIG);
  localparam int CW = $clog2(DIV);

  logic [6:0]      regs [NDIG];
  logic [CW-1:0]   cnt, ph;
  logic [AW-1:0]   idx, sidx;
  logic [6:0]      shadow;
  logic [BW-1:0]   bright_q;
  logic [1:0]      wrap_pipe;
  logic            cnt_end, idx_end, lit;
  logic [6:0]      glyph;
  logic [NDIG-1:0] an_sel;

  assign cnt_end = (cnt == CW'(DIV-1));
  assign idx_end = (idx == AW'(NDIG-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) regs[i] <= '0;
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NDIG))) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  // ph/sidx trail cnt/idx by one clock so the shadow is already valid at slot position 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      ph        <= '0;
      sidx      <= '0;
      shadow    <= '0;
      bright_q  <= '0;
      wrap_pipe <= '0;
    end else begin
      cnt  <= cnt_end ? '0 : cnt + CW'(1);
      if (cnt_end) idx <= idx_end ? '0 : idx + AW'(1);
      ph   <= cnt;
      sidx <= idx;
      if (cnt == '0) begin
        shadow   <= regs[idx];
        bright_q <= bus.bright;
      end
      wrap_pipe <= {wrap_pipe[0], cnt_end && idx_end};
    end
  end

  assign lit = shadow[6] && (BW'(ph) < bright_q);

  always_comb begin
    an_sel = '1;
    if (lit) an_sel[sidx] = 1'b0;
  end

  always_comb begin
    case (shadow[4:0])
      5'h00: glyph = 7'h40;
      5'h01: glyph = 7'h79;
      5'h02: glyph = 7'h24;
      5'h03: glyph = 7'h30;
      5'h04: glyph = 7'h19;
      5'h05: glyph = 7'h12;
      5'h06: glyph = 7'h02;
      5'h07: glyph = 7'h78;
      5'h08: glyph = 7'h00;
      5'h09: glyph = 7'h10;
      5'h0A: glyph = 7'h08;
      5'h0B: glyph = 7'h03;
      5'h0C: glyph = 7'h46;
      5'h0D: glyph = 7'h21;
      5'h0E: glyph = 7'h06;
      5'h0F: glyph = 7'h0E;
      5'h10: glyph = 7'h3F;
      5'h11: glyph = 7'h77;
      5'h12: glyph = 7'h09;
      5'h13: glyph = 7'h47;
      5'h14: glyph = 7'h0C;
      default: glyph = 7'h7F;
    endcase
  end

  // Segments and dp are forced dark whenever the anode is off to avoid ghosting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.an_n   <= '1;
      bus.segs_n <= 7'h7F;
      bus.dp_n   <= 1'b1;
      bus.frame  <= 1'b0;
    end else begin
      bus.an_n   <= an_sel;
      bus.segs_n <= lit ? glyph : 7'h7F;
      bus.dp_n   <= ~(lit && shadow[5]);
      bus.frame  <= wrap_pipe[1];
    end
  end
endmodule

// File: tb/tb_sevenseg_scan_n.sv
// Bench for sevenseg_scan_n: NDIG=4 and NDIG=3 instances checked against a time-based display model.
module tb_sevenseg_scan_n;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sevenseg_scan_n_if #(.NDIG(4), .BW(3)) b4 ();
  sevenseg_scan_n_if #(.NDIG(3), .BW(3)) b3 ();

  sevenseg_scan_n #(.NDIG(4), .DIV(DIV)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  sevenseg_scan_n #(.NDIG(3), .DIV(DIV)) dut3 (.clk(clk), .rst(rst), .bus(b3));

  int vectors = 0;
  int miscompares = 0;

  logic [24:0] obs4, obs3;
  assign obs4 = {12'hFFF,  b4.an_n, b4.segs_n, b4.dp_n, b4.frame};
  assign obs3 = {13'h1FFF, b3.an_n, b3.segs_n, b3.dp_n, b3.frame};

  function automatic logic [6:0] glyph_of(input logic [4:0] c);
    case (c)
      5'h00: return 7'h40;  5'h01: return 7'h79;  5'h02: return 7'h24;  5'h03: return 7'h30;
      5'h04: return 7'h19;  5'h05: return 7'h12;  5'h06: return 7'h02;  5'h07: return 7'h78;
      5'h08: return 7'h00;  5'h09: return 7'h10;  5'h0A: return 7'h08;  5'h0B: return 7'h03;
      5'h0C: return 7'h46;  5'h0D: return 7'h21;  5'h0E: return 7'h06;  5'h0F: return 7'h0E;
      5'h10: return 7'h3F;  5'h11: return 7'h77;  5'h12: return 7'h09;  5'h13: return 7'h47;
      5'h14: return 7'h0C;
      default: return 7'h7F;
    endcase
  endfunction

  // Outputs after the m-th edge since reset release show scan position m-2.
  function automatic logic [24:0] expect_out(input int m, input logic [6:0] lat,
                                             input logic [2:0] lb, input int nd);
    logic [15:0] an;
    logic [6:0]  sg;
    logic        dp, fr;
    int t, pos, dig;
    an = '1; sg = 7'h7F; dp = 1'b1; fr = 1'b0;
    if (m >= 2) begin
      t   = m - 2;
      pos = t % DIV;
      dig = (t / DIV) % nd;
      fr  = (t > 0) && (t % (nd * DIV) == 0);
      if (lat[6] && pos < int'(lb)) begin
        an[dig] = 1'b0;
        sg      = glyph_of(lat[4:0]);
        dp      = ~lat[5];
      end
    end
    return {an, sg, dp, fr};
  endfunction

  int m4, m3;
  logic [6:0]  r4 [4];
  logic [6:0]  r3 [3];
  logic [6:0]  l4, l3;
  logic [2:0]  lb4, lb3;
  logic [24:0] exp4, exp3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m4 <= 0; l4 <= '0; lb4 <= '0; exp4 <= {16'hFFFF, 7'h7F, 2'b10};
      for (int i = 0; i < 4; i++) r4[i] <= '0;
    end else begin
      exp4 <= expect_out(m4 + 1, l4, lb4, 4);
      m4   <= m4 + 1;
      if (m4 % DIV == 0) begin l4 <= r4[(m4 / DIV) % 4]; lb4 <= b4.bright; end
      if (b4.wr_en) r4[b4.wr_addr] <= b4.wr_data;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m3 <= 0; l3 <= '0; lb3 <= '0; exp3 <= {16'hFFFF, 7'h7F, 2'b10};
      for (int i = 0; i < 3; i++) r3[i] <= '0;
    end else begin
      exp3 <= expect_out(m3 + 1, l3, lb3, 3);
      m3   <= m3 + 1;
      if (m3 % DIV == 0) begin l3 <= r3[(m3 / DIV) % 3]; lb3 <= b3.bright; end
      if (b3.wr_en && int'(b3.wr_addr) < 3) r3[b3.wr_addr] <= b3.wr_data;
    end
  end

  task automatic wr4(input logic [1:0] a, input logic [6:0] d);
    @(negedge clk); b4.wr_en = 1'b1; b4.wr_addr = a; b4.wr_data = d;
    @(negedge clk); b4.wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [1:0] a, input logic [6:0] d);
    @(negedge clk); b3.wr_en = 1'b1; b3.wr_addr = a; b3.wr_data = d;
    @(negedge clk); b3.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0; b4.bright = 3'd4; b3.bright = 3'd4;
    wr4(1, 7'h48);
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    vectors++;
    if (obs4 !== {12'hFFF, 4'hF, 7'h7F, 2'b10}) begin
      miscompares++; $display("FAIL reset_dut4 got %h want %h", obs4, {12'hFFF, 4'hF, 7'h7F, 2'b10});
    end
    vectors++;
    if (obs3 !== {13'h1FFF, 3'h7, 7'h7F, 2'b10}) begin
      miscompares++; $display("FAIL reset_dut3 got %h want %h", obs3, {13'h1FFF, 3'h7, 7'h7F, 2'b10});
    end
    @(negedge clk); rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vectors++;
      if (b4.an_n !== 4'hF) begin miscompares++; $display("FAIL reset_dark an_n got %h want f", b4.an_n); end
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL reset_model got %h want %h", obs4, exp4); end
    end
  endtask

  task automatic test_single();
    int hit, dark, dpc;
    wr4(0, 7'h43);
    repeat (20) @(negedge clk);
    hit = 0; dark = 0;
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL single_model got %h want %h", obs4, exp4); end
      if (b4.an_n == 4'hE && b4.segs_n == 7'h30 && b4.dp_n == 1'b1) hit++;
      if (b4.an_n == 4'hF) dark++;
    end
    vectors++;
    if (hit !== 4) begin miscompares++; $display("FAIL single_lit got %0d want 4", hit); end
    vectors++;
    if (dark !== 12) begin miscompares++; $display("FAIL single_dark got %0d want 12", dark); end
    wr4(0, 7'h63);
    repeat (20) @(negedge clk);
    dpc = 0;
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL single_dp_model got %h want %h", obs4, exp4); end
      if (b4.an_n == 4'hE && b4.dp_n == 1'b0) dpc++;
    end
    vectors++;
    if (dpc !== 4) begin miscompares++; $display("FAIL single_dp got %0d want 4", dpc); end
  endtask

  task automatic test_full_scan();
    logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] sg_tab [4] = '{7'h40, 7'h79, 7'h08, 7'h3F};
    int frames, last, t, k;
    wr4(0, 7'h40); wr4(1, 7'h41); wr4(2, 7'h4A); wr4(3, 7'h50);
    repeat (20) @(negedge clk);
    frames = 0; last = -1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL scan_model got %h want %h", obs4, exp4); end
      t = m4 - 2;
      if (t % DIV == 0) begin
        k = (t / DIV) % 4;
        vectors++;
        if (b4.an_n !== an_tab[k] || b4.segs_n !== sg_tab[k]) begin
          miscompares++;
          $display("FAIL scan_slot%0d got %h/%h want %h/%h", k, b4.an_n, b4.segs_n, an_tab[k], sg_tab[k]);
        end
      end
      if (b4.frame) begin
        frames++;
        if (last >= 0) begin
          vectors++;
          if (c - last !== 16) begin miscompares++; $display("FAIL frame_gap got %0d want 16", c - last); end
        end
        last = c;
      end
    end
    vectors++;
    if (frames !== 2) begin miscompares++; $display("FAIL frame_count got %0d want 2", frames); end
  endtask

  task automatic test_bright();
    logic [2:0] bv [3] = '{3'd1, 3'd0, 3'd7};
    int bexp [3] = '{4, 0, 16};
    int on;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); b4.bright = bv[j];
      repeat (8) @(negedge clk);
      on = 0;
      repeat (16) begin
        @(negedge clk);
        vectors++;
        if (obs4 !== exp4) begin miscompares++; $display("FAIL bright_model got %h want %h", obs4, exp4); end
        if (b4.an_n != 4'hF) on++;
      end
      vectors++;
      if (on !== bexp[j]) begin miscompares++; $display("FAIL bright%0d on got %0d want %0d", bv[j], on, bexp[j]); end
    end
    b4.bright = 3'd4;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_collision();
    for (int i = 0; i < 20 && (m4 % 16) != 4; i++) @(negedge clk);
    vectors++;
    if (m4 % 16 != 4) begin miscompares++; $display("FAIL coll_align got %0d want 4", m4 % 16); end
    b4.wr_en = 1'b1; b4.wr_addr = 2'd1; b4.wr_data = 7'h48;
    @(negedge clk); b4.wr_en = 1'b0;
    @(negedge clk);
    vectors++;
    if (b4.an_n !== 4'hD || b4.segs_n !== 7'h79) begin
      miscompares++; $display("FAIL coll_old got %h/%h want d/79", b4.an_n, b4.segs_n);
    end
    repeat (16) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL coll_model got %h want %h", obs4, exp4); end
    end
    vectors++;
    if (b4.an_n !== 4'hD || b4.segs_n !== 7'h00) begin
      miscompares++; $display("FAIL coll_new got %h/%h want d/00", b4.an_n, b4.segs_n);
    end
  endtask

  task automatic test_edge_codes();
    wr4(2, 7'h55);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 20 && (m4 % 16) != 10; i++) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL edge_model got %h want %h", obs4, exp4); end
    end
    vectors++;
    if (b4.an_n !== 4'hB || b4.segs_n !== 7'h7F || b4.dp_n !== 1'b1) begin
      miscompares++; $display("FAIL edge_blank got %h/%h/%b want b/7f/1", b4.an_n, b4.segs_n, b4.dp_n);
    end
  endtask

  task automatic test_ndig3();
    int frames, last;
    wr3(0, 7'h40); wr3(1, 7'h41); wr3(2, 7'h4A); wr3(3, 7'h48);
    repeat (20) @(negedge clk);
    frames = 0; last = -1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      vectors++;
      if (obs3 !== exp3) begin miscompares++; $display("FAIL n3_model got %h want %h", obs3, exp3); end
      if (b3.frame) begin
        frames++;
        vectors++;
        if (b3.an_n !== 3'h6 || b3.segs_n !== 7'h40) begin
          miscompares++; $display("FAIL n3_wrap got %h/%h want 6/40", b3.an_n, b3.segs_n);
        end
        if (last >= 0) begin
          vectors++;
          if (c - last !== 12) begin miscompares++; $display("FAIL n3_gap got %0d want 12", c - last); end
        end
        last = c;
      end
    end
    vectors++;
    if (frames !== 3) begin miscompares++; $display("FAIL n3_frames got %0d want 3", frames); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      vectors++;
      if (obs4 !== exp4) begin miscompares++; $display("FAIL rand_dut4 got %h want %h", obs4, exp4); end
      vectors++;
      if (obs3 !== exp3) begin miscompares++; $display("FAIL rand_dut3 got %h want %h", obs3, exp3); end
      b4.wr_en   = 1'($urandom_range(0, 1));
      b4.wr_addr = 2'($urandom_range(0, 3));
      b4.wr_data = 7'($urandom);
      b3.wr_en   = 1'($urandom_range(0, 1));
      b3.wr_addr = 2'($urandom_range(0, 3));
      b3.wr_data = 7'($urandom);
      if (c % 8 == 0) begin
        b4.bright = 3'($urandom_range(0, 7));
        b3.bright = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clk);
    b4.wr_en = 1'b0; b3.wr_en = 1'b0;
  endtask

  initial begin
    b4.wr_en = 1'b0; b4.wr_addr = '0; b4.wr_data = '0; b4.bright = '0;
    b3.wr_en = 1'b0; b3.wr_addr = '0; b3.wr_data = '0; b3.bright = '0;
    test_reset();
    test_single();
    test_full_scan();
    test_bright();
    test_collision();
    test_edge_codes();
    test_ndig3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
